// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: default width,
// FSM state encodings and the bit-counter width helper.
package serial_add_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// Single-bit full adder cell; shared with the parallel add/sub unit.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry
// flop, LSB first. Handshakes: a transfer happens on a rising edge where
// valid and ready are both high; valid holders keep data stable until then.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic             M,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   sum2,
  output logic             busy
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum_q;
  logic             fa_s, fa_cout;

  full_adder_1bit u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_cout)
  );

  // New sum bit enters at the MSB while older bits move toward the LSB.
  assign sum_next = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid) state_d = SHIFT;
      SHIFT:   if (cnt == LAST) state_d = DONE;
      DONE:    if (res_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            // Subtraction is A + ~B + 1: invert B here, seed carry with M.
            a_sh  <= A1;
            b_sh  <= B1 ^ {WIDTH{M}};
            carry <= M;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
          // Publish on the last bit so sum2 is already final in DONE.
          if (cnt == LAST) sum_q <= {fa_cout, sum_next};
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign sum2        = sum_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: table-driven vectors, hand-written
// reset/backpressure sequences and a random stream against a queue scoreboard.
module tb_serial_add_sub;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic [W:0]   exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] A1 = '0;
  logic [W-1:0] B1 = '0;
  logic         M = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W:0]   sum2;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_pop    = 0;
  int res_seen = 0;
  logic [W:0] exp_q[$];

  serial_add_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .A1         (A1),
    .B1         (B1),
    .M          (M),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .sum2       (sum2),
    .busy       (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [W:0] ref_model(logic [W-1:0] a, logic [W-1:0] b, logic m);
    logic [W:0] bx;
    bx = {1'b0, b ^ {W{m}}};
    return {1'b0, a} + bx + {{W{1'b0}}, m};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- scoreboard monitor ----------------
  // Inputs change only just after a rising edge, so the falling edge shows
  // exactly what the next rising edge will see.
  always @(negedge clk) begin
    if (rst_n) begin
      if (start_valid && start_ready) begin
        exp_q.push_back(ref_model(A1, B1, M));
        n_push++;
      end
      if (res_valid) res_seen++;
      if (res_valid && res_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard: unexpected result %0h", sum2);
        end else begin
          check("scoreboard", 32'(sum2), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        output logic [W:0] res, output int lat);
    int n;
    start_valid = 1'b1; A1 = a; B1 = b; M = m; res_ready = 1'b1;
    n = 0;
    while (!start_ready && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("start_accept");
    tick();
    start_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin tick(); lat++; end
    if (lat >= 20) timeout("result_wait");
    res = sum2;
    tick();
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (cycles) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- test ----------------
  vec_t vecs[8];

  initial begin
    logic [W:0] res;
    int lat, issued, cyc, pop_base, seen_base;
    logic acc;

    vecs[0] = '{a: 4'b1111, b: 4'b1111, m: 1'b0, exp: 5'b11110};
    vecs[1] = '{a: 4'b0100, b: 4'b0101, m: 1'b0, exp: 5'b01001};
    vecs[2] = '{a: 4'b1111, b: 4'b0111, m: 1'b1, exp: 5'b11000};
    vecs[3] = '{a: 4'b1111, b: 4'b1111, m: 1'b1, exp: 5'b10000};
    vecs[4] = '{a: 4'b1000, b: 4'b1111, m: 1'b1, exp: 5'b01001};
    vecs[5] = '{a: 4'b0000, b: 4'b0000, m: 1'b0, exp: 5'b00000};
    vecs[6] = '{a: 4'b0000, b: 4'b0000, m: 1'b1, exp: 5'b10000};
    vecs[7] = '{a: 4'b0000, b: 4'b0001, m: 1'b1, exp: 5'b01111};

    // Reset state
    #2;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_res_valid",   32'(res_valid),   32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_sum2",        32'(sum2),        32'd0);
    apply_reset(2);

    // Table-driven vectors with latency check
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, res, lat);
      check($sformatf("vec%0d_sum2", i), 32'(res), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
    end
    check("idle_after_ops", 32'(start_ready), 32'd1);

    // Reset mid-operation: sum2 currently holds the last vector result
    start_valid = 1'b1; A1 = 4'b1100; B1 = 4'b0011; M = 1'b0; res_ready = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_res_valid",   32'(res_valid),   32'd0);
    check("mid_rst_busy",        32'(busy),        32'd0);
    check("mid_rst_sum2",        32'(sum2),        32'd0);
    check("mid_rst_start_ready", 32'(start_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    seen_base = res_seen;
    repeat (10) tick();
    check("mid_rst_no_result", 32'(res_seen - seen_base), 32'd0);

    // Backpressure with a second request held during SHIFT/DONE
    res_ready = 1'b0;
    start_valid = 1'b1; A1 = 4'b1110; B1 = 4'b1101; M = 1'b0;
    tick();
    A1 = 4'b0011; B1 = 4'b0001; M = 1'b1;
    cyc = 0;
    while (!res_valid && cyc < 20) begin tick(); cyc++; end
    if (cyc >= 20) timeout("bp_result_wait");
    for (int k = 0; k < 5; k++) begin
      check("bp_sum2",        32'(sum2),        32'h1B);
      check("bp_res_valid",   32'(res_valid),   32'd1);
      check("bp_start_ready", 32'(start_ready), 32'd0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    check("bp_consumed_valid", 32'(res_valid),   32'd0);
    check("bp_idle_ready",     32'(start_ready), 32'd1);
    check("bp_sum2_retained",  32'(sum2),        32'h1B);
    tick();
    check("bp_second_accepted", 32'(busy), 32'd1);
    start_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 20) begin tick(); cyc++; end
    if (cyc >= 20) timeout("bp_second_wait");
    check("bp_second_sum2", 32'(sum2), 32'h12);
    tick();

    // Random stream with random gaps and backpressure
    pop_base = n_pop;
    issued = 0;
    cyc = 0;
    while ((n_pop - pop_base) < 200 && cyc < 3000) begin
      acc = start_valid && start_ready;
      tick();
      cyc++;
      if (acc) issued++;
      res_ready = ($urandom_range(0, 3) != 0);
      if (!start_valid || acc) begin
        if (issued < 200 && $urandom_range(0, 1) == 1) begin
          start_valid = 1'b1;
          A1 = W'($urandom_range(0, 15));
          B1 = W'($urandom_range(0, 15));
          M  = 1'($urandom_range(0, 1));
        end else begin
          start_valid = 1'b0;
        end
      end
    end
    if (cyc >= 3000) timeout("random_stream");
    start_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    check("random_results", 32'(n_pop - pop_base), 32'd200);
    check("random_issued",  32'(issued),           32'd200);
    check("queue_empty",    32'(exp_q.size()),     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
